// File: rtl/cond_unit.sv
// Condition-code unit: evaluates the instruction condition against registered flags, with a save/restore shadow.
// o_CondEx is combinational from i_Cond and o_Flags; flag, save and restore updates appear one cycle after the edge.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic [3:0] i_Cond,
  input  logic [3:0] i_ALU_Flags,
  input  logic [1:0] i_FlagWrite,
  input  logic       i_Save,
  input  logic       i_Restore,
  output logic       o_CondEx,
  output logic [3:0] o_Flags,
  output logic [3:0] o_SavedFlags
);

  logic [3:0] flags_q, flags_d;
  logic [3:0] saved_q, saved_d;
  logic       n_flag, z_flag, c_flag, v_flag;
  logic       cond_ex;

  assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

  always_comb begin
    cond_ex = 1'b0;
    unique case (i_Cond)
      4'b0000: cond_ex = z_flag;
      4'b0001: cond_ex = ~z_flag;
      4'b0010: cond_ex = c_flag;
      4'b0011: cond_ex = ~c_flag;
      4'b0100: cond_ex = n_flag;
      4'b0101: cond_ex = ~n_flag;
      4'b0110: cond_ex = v_flag;
      4'b0111: cond_ex = ~v_flag;
      4'b1000: cond_ex = c_flag & ~z_flag;
      4'b1001: cond_ex = ~c_flag | z_flag;
      4'b1010: cond_ex = (n_flag == v_flag);
      4'b1011: cond_ex = (n_flag != v_flag);
      4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
      4'b1101: cond_ex = z_flag | (n_flag != v_flag);
      default: cond_ex = 1'b1;
    endcase
  end

  // Restore wins over a flag write in the same cycle; unenabled halves hold.
  always_comb begin
    flags_d = flags_q;
    if (i_Restore) begin
      flags_d = saved_q;
    end else if (cond_ex) begin
      if (i_FlagWrite[1]) flags_d[3:2] = i_ALU_Flags[3:2];
      if (i_FlagWrite[0]) flags_d[1:0] = i_ALU_Flags[1:0];
    end
  end

  // Save always captures the pre-edge flags, which makes save+restore a swap.
  always_comb begin
    saved_d = saved_q;
    if (i_Save) saved_d = flags_q;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      flags_q <= RESET_FLAGS;
      saved_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
      saved_q <= saved_d;
    end
  end

  assign o_CondEx     = cond_ex;
  assign o_Flags      = flags_q;
  assign o_SavedFlags = saved_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit: scenario vectors plus an exhaustive condition/flag sweep.
module tb_cond_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cond;
  logic [3:0] alu_flags;
  logic [1:0] flag_write;
  logic       save;
  logic       restore;
  logic       cond_ex;
  logic [3:0] flags;
  logic [3:0] saved_flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cond_unit dut (
    .i_Clock     (clk),
    .i_Reset     (rst),
    .i_Cond      (cond),
    .i_ALU_Flags (alu_flags),
    .i_FlagWrite (flag_write),
    .i_Save      (save),
    .i_Restore   (restore),
    .o_CondEx    (cond_ex),
    .o_Flags     (flags),
    .o_SavedFlags(saved_flags)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] v);
    cond = 4'b1110; flag_write = 2'b11; alu_flags = v;
    tick();
    flag_write = 2'b00;
  endtask

  // Reference grouped by condition pairs: even code tests a predicate, odd code inverts it.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = ~(n ^ v);
      3'd6: base = ~z & ~(n ^ v);
      default: base = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? 1'b1 : (base ^ c[0]);
  endfunction

  initial begin
    rst = 1'b1; cond = 4'b0000; alu_flags = 4'b0000;
    flag_write = 2'b00; save = 1'b0; restore = 1'b0;
    #1;
    tick(); tick();
    rst = 1'b0;
    check("rst_flags", flags, 4'b0000);
    check("rst_saved", saved_flags, 4'b0000);
    cond = 4'b0000; #1;
    check("rst_eq", {3'b0, cond_ex}, 4'd0);
    cond = 4'b0001; #1;
    check("rst_ne", {3'b0, cond_ex}, 4'd1);

    // Z update under AL, visible next cycle
    alu_flags = 4'b0100; flag_write = 2'b11; cond = 4'b1110;
    tick();
    flag_write = 2'b00;
    check("upd_flags", flags, 4'b0100);
    cond = 4'b0000; #1;
    check("upd_eq", {3'b0, cond_ex}, 4'd1);

    // Failing condition suppresses the write
    set_flags(4'b0000);
    cond = 4'b0000; flag_write = 2'b11; alu_flags = 4'b1111;
    tick();
    flag_write = 2'b00;
    check("fail_nowrite", flags, 4'b0000);

    // C,V-only update holds N,Z
    set_flags(4'b1010);
    flag_write = 2'b01; alu_flags = 4'b0101; cond = 4'b1110;
    tick();
    flag_write = 2'b00;
    check("cv_only", flags, 4'b1001);
    cond = 4'b1010; #1;
    check("ge", {3'b0, cond_ex}, 4'd1);
    cond = 4'b1011; #1;
    check("lt", {3'b0, cond_ex}, 4'd0);

    // N,Z-only update holds C,V
    flag_write = 2'b10; alu_flags = 4'b0110; cond = 4'b1110;
    tick();
    flag_write = 2'b00;
    check("nz_only", flags, 4'b0101);

    // Save+restore swap
    set_flags(4'b0011);
    save = 1'b1; tick(); save = 1'b0;
    set_flags(4'b1100);
    check("pre_swap_saved", saved_flags, 4'b0011);
    save = 1'b1; restore = 1'b1;
    tick();
    save = 1'b0; restore = 1'b0;
    check("swap_flags", flags, 4'b0011);
    check("swap_saved", saved_flags, 4'b1100);

    // Restore overrides an enabled flag write
    set_flags(4'b0010);
    save = 1'b1; tick(); save = 1'b0;
    set_flags(4'b0000);
    restore = 1'b1; flag_write = 2'b11; alu_flags = 4'b1111; cond = 4'b1110;
    tick();
    restore = 1'b0; flag_write = 2'b00;
    check("restore_prio", flags, 4'b0010);

    // Save alongside an update keeps pre-update flags
    set_flags(4'b0110);
    save = 1'b1; flag_write = 2'b11; alu_flags = 4'b1001; cond = 4'b1110;
    tick();
    save = 1'b0; flag_write = 2'b00;
    check("save_upd_saved", saved_flags, 4'b0110);
    check("save_upd_flags", flags, 4'b1001);

    // Restore under a failing condition still acts
    cond = 4'b0000; restore = 1'b1;
    tick();
    restore = 1'b0;
    check("restore_nocond", flags, 4'b0110);

    // Garbage ALU flags with no write enable
    alu_flags = 4'bxxxx; flag_write = 2'b00; cond = 4'b1110;
    tick();
    check("x_noupd", flags, 4'b0110);
    alu_flags = 4'b0000;

    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c); #1;
        check($sformatf("sweep_c%0d_f%0d", c, f), {3'b0, cond_ex},
              {3'b0, ref_cond(4'(c), 4'(f))});
      end
    end

    // Reset discards a concurrent save
    set_flags(4'b1111);
    save = 1'b1; rst = 1'b1;
    tick();
    save = 1'b0; rst = 1'b0;
    check("rst_save_saved", saved_flags, 4'b0000);
    check("rst_save_flags", flags, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
